cache_req_ctrl: RTL

- Initiator side of the cache access port: the block that drives enab/rw/Addr/data_in into the cache and consumes hit/data_out.
- Accepts one load/store at a time from the CPU datapath over a valid/ready handshake and issues it to the cache.
- On a miss, waits a fixed fill penalty and re-issues; returns read data or write completion over a held response handshake.
- Sits between the CPU memory stage and the cache.

---
 rtl/cache_req_ctrl_if.sv | 34 +++
 rtl/cache_req_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cache_req_ctrl_if.sv
// Bus bundle between the CPU memory stage, cache_req_ctrl and the cache.
// slave: the controller's view; master: the CPU plus cache around it.
interface cache_req_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          cache_enab;
  logic          cache_rw;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic [DW-1:0] cache_rdata;
  logic          cache_hit;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready, cache_rdata, cache_hit,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output cache_enab, cache_rw, cache_addr, cache_wdata
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready, cache_rdata, cache_hit,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  cache_enab, cache_rw, cache_addr, cache_wdata
  );
endinterface

// File: rtl/cache_req_ctrl.sv
// Cache access initiator: one load/store at a time, fixed-penalty miss retry, held response.
// Optional hit/miss counters under macro CACHE_REQ_STATS_EN.
module cache_req_ctrl #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MISS_WAIT = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              clr,
  cache_req_ctrl_if.slave   bus,
  output logic              busy
`ifdef CACHE_REQ_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int unsigned RW = 3;
  localparam int unsigned WW = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CHECK   = 3'd2,
    S_BACKOFF = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e        state_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          rsp_err_q;
  logic          enab_q;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          busy_q;
  logic [RW-1:0] retry_q;
  logic [WW-1:0] wait_q;

  // Request fields stay frozen in the cache_* registers until the response is consumed.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      enab_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      retry_q     <= '0;
      wait_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            rw_q        <= bus.req_rw;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            retry_q     <= '0;
            enab_q      <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          enab_q  <= 1'b0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.cache_hit) begin
            rsp_rdata_q <= rw_q ? '0 : bus.cache_rdata;
            rsp_err_q   <= 1'b0;
            state_q     <= S_RESP;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_q <= retry_q + RW'(1);
            wait_q  <= WW'(MISS_WAIT);
            state_q <= S_BACKOFF;
          end else begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_BACKOFF: begin
          // Leaving on the cycle the counter hits zero gives exactly MISS_WAIT cycles here.
          wait_q <= wait_q - WW'(1);
          if (wait_q == WW'(1)) begin
            enab_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.cache_enab  = enab_q;
  assign bus.cache_rw    = rw_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = wdata_q;
  assign busy            = busy_q;

`ifdef CACHE_REQ_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating counters of CHECK outcomes, retries included.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_CHECK) begin
      if (bus.cache_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
